// File: rtl/y_alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 captures operands, S2 holds the result and flags.
// Each stage advances independently, so a full pipe can pop and push in the same cycle.
module y_alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             ex
);
  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] z;
    logic             zero;
    logic             ex;
  } rsp_t;

  logic [2:1]       vld_pipe;
  req_t             s1;
  rsp_t             s2, res;
  logic             s2_load, push;
  logic [WIDTH-1:0] sum, diff;
  logic             add_ov, sub_ov;

  assign s2_load  = vld_pipe[1] & (~vld_pipe[2] | out_ready);
  assign in_ready = ~vld_pipe[1] | s2_load;
  assign push     = in_valid & in_ready;

  assign sum    = s1.a + s1.b;
  assign diff   = s1.a - s1.b;
  assign add_ov = (s1.a[MSB] == s1.b[MSB]) & (sum[MSB] != s1.a[MSB]);
  assign sub_ov = (s1.a[MSB] != s1.b[MSB]) & (diff[MSB] != s1.a[MSB]);

  always_comb begin
    res.z  = '0;
    res.ex = 1'b0;
    case (s1.op)
      3'b000: res.z = s1.a & s1.b;
      3'b001: res.z = s1.a | s1.b;
      3'b010: begin res.z = sum; res.ex = add_ov; end
      3'b011: res.z = {{(WIDTH-1){1'b0}}, (s1.a < s1.b)};
      3'b100: res.z = s1.a ^ s1.b;
      3'b101: res.z = ~(s1.a | s1.b);
      3'b110: begin res.z = diff; res.ex = sub_ov; end
      // signed compare stays correct when a-b overflows
      default: res.z = {{(WIDTH-1){1'b0}}, (diff[MSB] ^ sub_ov)};
    endcase
    res.zero = (res.z == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (push) begin
        vld_pipe[1] <= 1'b1;
        s1          <= {op, a, b};
      end else if (s2_load) begin
        vld_pipe[1] <= 1'b0;
      end
      if (s2_load) begin
        vld_pipe[2] <= 1'b1;
        s2          <= res;
      end else if (out_ready) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

  // outputs read zero whenever no result is being presented
  assign out_valid = vld_pipe[2];
  assign z         = out_valid ? s2.z : '0;
  assign zero      = out_valid & s2.zero;
  assign ex        = out_valid & s2.ex;
endmodule

// File: tb/tb_y_alu_pipe.sv
// Directed and random checks of y_alu_pipe at WIDTH=32 and WIDTH=8.
module tb_y_alu_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv32, rdy32, ov32, ordy32, zr32, ex32;
  logic [31:0] a32, b32, z32;
  logic [2:0]  op32;
  logic        iv8, rdy8, ov8, ordy8, zr8, ex8;
  logic [7:0]  a8, b8, z8;
  logic [2:0]  op8;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [65:0] q32[$];
  logic [65:0] q8[$];

  always #5 clk = ~clk;

  y_alu_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32), .a(a32), .b(b32), .op(op32),
    .out_valid(ov32), .out_ready(ordy32), .z(z32), .zero(zr32), .ex(ex32));

  y_alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .a(a8), .b(b8), .op(op8),
    .out_valid(ov8), .out_ready(ordy8), .z(z8), .zero(zr8), .ex(ex8));

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: signed math on sign-extended 64-bit values, overflow by range test
  function automatic logic [65:0] model(input int w, input logic [2:0] o,
                                        input logic [63:0] x, input logic [63:0] y);
    longint      sa, sb, r, t, maxv, minv;
    logic [63:0] m, zz;
    logic        ov;
    m    = (64'd1 << w) - 64'd1;
    t    = longint'(x << (64 - w)); sa = t >>> (64 - w);
    t    = longint'(y << (64 - w)); sb = t >>> (64 - w);
    maxv = (longint'(1) << (w - 1)) - 1;
    minv = -(longint'(1) << (w - 1));
    ov   = 1'b0;
    zz   = '0;
    case (o)
      3'd0: zz = x & y;
      3'd1: zz = x | y;
      3'd2: begin r = sa + sb; zz = r; ov = (r > maxv) || (r < minv); end
      3'd3: zz = (x < y) ? 64'd1 : 64'd0;
      3'd4: zz = x ^ y;
      3'd5: zz = ~(x | y);
      3'd6: begin r = sa - sb; zz = r; ov = (r > maxv) || (r < minv); end
      default: zz = (sa < sb) ? 64'd1 : 64'd0;
    endcase
    zz = zz & m;
    return {ov, (zz == 64'd0), zz};
  endfunction

  task automatic one32(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ez, input logic ezr,
                       input logic eex);
    @(posedge clk); #1;
    iv32 = 1'b1; op32 = o; a32 = x; b32 = y; ordy32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, ov32, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, ov32, 1'b1);
    chk({tag, "_z"}, z32, ez);
    chk({tag, "_zero"}, zr32, ezr);
    chk({tag, "_ex"}, ex32, eex);
  endtask

  initial begin
    int          i, n, k, cnt, cyc, sent32, sent8, got32, got8;
    logic        acc;
    logic [65:0] e;
    rst_n = 1'b0;
    iv32 = 1'b0; a32 = '0; b32 = '0; op32 = '0; ordy32 = 1'b1;
    iv8  = 1'b0; a8  = '0; b8  = '0; op8  = '0; ordy8  = 1'b1;
    #3;
    chk("rst_ov", ov32, 1'b0);
    chk("rst_z", z32, 32'd0);
    chk("rst_zero", zr32, 1'b0);
    chk("rst_ex", ex32, 1'b0);
    chk("rst_rdy", rdy32, 1'b1);
    #9 rst_n = 1'b1;

    one32("sub_neg", 3'b110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    one32("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    one32("sub_ovf", 3'b110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    one32("slt_m1", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    one32("sltu_m1", 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    one32("slt_ovf", 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    one32("and_zero", 3'b000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0, 1'b1, 1'b0);
    one32("nor_zero", 3'b101, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0, 1'b1, 1'b0);
    one32("or", 3'b001, 32'h0000_1234, 32'h0000_00F0, 32'h0000_12F4, 1'b0, 1'b0);
    one32("xor", 3'b100, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1'b0, 1'b0);
    one32("add", 3'b010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);

    // backpressure: beat i is ADD (i+1)+100
    @(posedge clk); #1;
    ordy32 = 1'b0; i = 0;
    for (int c = 0; c < 6; c++) begin
      iv32 = 1'b1; op32 = 3'b010; a32 = 32'(i + 1); b32 = 32'd100;
      @(negedge clk);
      acc = rdy32;
      if (c >= 2) begin
        chk("bp_stall_rdy", rdy32, 1'b0);
        chk("bp_stall_vld", ov32, 1'b1);
        chk("bp_stall_z", z32, 32'd101);
      end
      @(posedge clk); #1;
      if (acc) i++;
    end
    chk("bp_accepted", i, 2);
    ordy32 = 1'b1; n = 0; k = 0;
    while (n < 4 && k < 20) begin
      iv32 = (i < 4); op32 = 3'b010; a32 = 32'(i + 1); b32 = 32'd100;
      @(negedge clk);
      if (k == 0) chk("bp_release_rdy", rdy32, 1'b1);
      acc = iv32 && rdy32;
      if (ov32) begin
        chk("bp_order_z", z32, 32'(101 + n));
        n++;
      end
      @(posedge clk); #1;
      if (acc) i++;
      k++;
    end
    iv32 = 1'b0;
    chk("bp_out_count", n, 4);
    chk("bp_in_count", i, 4);

    // reset with two beats in flight
    @(posedge clk); #1;
    ordy32 = 1'b0; iv32 = 1'b1; op32 = 3'b010; a32 = 32'd1; b32 = 32'd1;
    @(posedge clk); #1;
    a32 = 32'd2;
    @(posedge clk); #1;
    iv32 = 1'b0;
    chk("rstm_pre_vld", ov32, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_ov", ov32, 1'b0);
    chk("rstm_z", z32, 32'd0);
    chk("rstm_rdy", rdy32, 1'b1);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b1; ordy32 = 1'b1; op32 = 3'b100; a32 = 32'hAAAA_0000; b32 = 32'h0000_AAAA;
    @(posedge clk); #1;
    iv32 = 1'b0; cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ov32) begin
        cnt++;
        chk("rstm_new_z", z32, 32'hAAAA_AAAA);
      end
    end
    chk("rstm_count", cnt, 1);

    // random regression on both widths against the model
    sent32 = 0; sent8 = 0; got32 = 0; got8 = 0; cyc = 0;
    @(posedge clk); #1;
    while ((got32 < 1000 || got8 < 1000) && cyc < 20000) begin
      iv32   = (sent32 < 1000) && ($urandom_range(0, 3) != 0);
      op32   = 3'($urandom_range(0, 7));
      a32    = $urandom;
      b32    = ($urandom_range(0, 7) == 0) ? a32 : $urandom;
      ordy32 = ($urandom_range(0, 3) != 0);
      iv8    = (sent8 < 1000) && ($urandom_range(0, 3) != 0);
      op8    = 3'($urandom_range(0, 7));
      a8     = 8'($urandom);
      b8     = ($urandom_range(0, 7) == 0) ? a8 : 8'($urandom);
      ordy8  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (iv32 && rdy32) begin
        q32.push_back(model(32, op32, {32'd0, a32}, {32'd0, b32}));
        sent32++;
      end
      if (ov32 && ordy32) begin
        if (q32.size() == 0) chk("rnd32_extra", 1'b1, 1'b0);
        else begin e = q32.pop_front(); chk("rnd32", {ex32, zr32, 32'd0, z32}, e); end
        got32++;
      end
      if (iv8 && rdy8) begin
        q8.push_back(model(8, op8, {56'd0, a8}, {56'd0, b8}));
        sent8++;
      end
      if (ov8 && ordy8) begin
        if (q8.size() == 0) chk("rnd8_extra", 1'b1, 1'b0);
        else begin e = q8.pop_front(); chk("rnd8", {ex8, zr8, 56'd0, z8}, e); end
        got8++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("rnd32_count", got32, 1000);
    chk("rnd8_count", got8, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
